// File: rtl/fp_pkg.sv
// Shared fp32 definitions for the MAC column (multiplier and accumulator).
package fp_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } acc_state_t;

  function automatic logic is_nan(input fp32_t f);
    return (f.exp == EXP_MAX) && (f.man != 23'd0);
  endfunction

  function automatic logic is_inf(input fp32_t f);
    return (f.exp == EXP_MAX) && (f.man == 23'd0);
  endfunction

  function automatic logic is_zero(input fp32_t f);
    return (f.exp == 8'd0) && (f.man == 23'd0);
  endfunction

endpackage

// File: rtl/fp_lzc27.sv
// Combinational leading-zero counter for the 27-bit normalisation datapath.
module fp_lzc27 (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Scanning upward lets the highest set bit win; all-zero input yields 27.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_acc.sv
// Iterative fp32 accumulator: one product per 5 cycles through align/add/norm/round.
module fp_acc
  import fp_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int FTZ   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  if (FTZ != 1) begin : g_ftz_check
    $error("fp_acc: only FTZ=1 (flush subnormals to zero) is supported");
  end

  acc_state_t       state;
  fp32_t            acc, op;
  logic             last_q;
  logic [CNT_W-1:0] count;

  // Stage registers; each is consumed by the next state only.
  logic        a_sign, a_sub, a_both_neg, a_spec;
  logic [31:0] a_spec_val;
  logic [7:0]  a_exp;
  logic [26:0] a_big, a_small;
  logic [27:0] s_sum;
  logic [26:0] n_man;
  logic [9:0]  n_exp;
  logic        n_zero;

  // ALIGN combinational datapath.
  logic        spec;
  logic [31:0] spec_val;
  logic [23:0] acc_m, op_m, big_m, small_m;
  logic [7:0]  big_e, small_e, diff;
  logic        big_s, op_gt;
  logic [26:0] small_x, shifted;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    spec     = 1'b0;
    spec_val = QNAN;
    if (is_nan(acc) || is_nan(op) ||
        (is_inf(acc) && is_inf(op) && (acc.sign != op.sign))) begin
      spec = 1'b1;
    end else if (is_inf(acc)) begin
      spec     = 1'b1;
      spec_val = acc;
    end else if (is_inf(op)) begin
      spec     = 1'b1;
      spec_val = op;
    end

    acc_m = (acc.exp == 8'd0) ? 24'd0 : {1'b1, acc.man};
    op_m  = (op.exp  == 8'd0) ? 24'd0 : {1'b1, op.man};
    op_gt = {op.exp, op_m} > {acc.exp, acc_m};

    big_e   = op_gt ? op.exp   : acc.exp;
    small_e = op_gt ? acc.exp  : op.exp;
    big_m   = op_gt ? op_m     : acc_m;
    small_m = op_gt ? acc_m    : op_m;
    big_s   = op_gt ? op.sign  : acc.sign;
    diff    = big_e - small_e;

    small_x = {small_m, 3'b000};
    if (diff >= 8'd26) begin
      shifted = {26'd0, |small_m};
    end else begin
      shifted    = small_x >> diff[4:0];
      shifted[0] = shifted[0] | (|(small_x & ((27'd1 << diff[4:0]) - 27'd1)));
    end
  end

  // NORM combinational datapath.
  logic [4:0]  lz;
  logic [26:0] norm_m;
  logic [9:0]  norm_e;
  logic        norm_z;

  fp_lzc27 u_lzc (
    .value (s_sum[26:0]),
    .count (lz)
  );

  always_comb begin
    norm_m = s_sum[26:0];
    norm_e = {2'b00, a_exp};
    norm_z = 1'b0;
    if (s_sum[27]) begin
      norm_m = {s_sum[27:2], s_sum[1] | s_sum[0]};
      norm_e = {2'b00, a_exp} + 10'd1;
    end else if (s_sum[26:0] == 27'd0) begin
      norm_z = 1'b1;
    end else begin
      norm_m = s_sum[26:0] << lz;
      norm_e = {2'b00, a_exp} - {5'd0, lz};
    end
  end

  // ROUND combinational datapath: nearest-even on guard/round/sticky.
  logic        rnd_up;
  logic [24:0] rnd_m;
  logic [9:0]  rnd_e;
  logic [31:0] result;

  always_comb begin
    rnd_up = n_man[2] & (n_man[1] | n_man[0] | n_man[3]);
    rnd_m  = {1'b0, n_man[26:3]} + {24'd0, rnd_up};
    rnd_e  = n_exp + {9'd0, rnd_m[24]};
    if (a_spec)
      result = a_spec_val;
    else if (n_zero)
      result = {a_both_neg, 31'd0};
    else if (rnd_e[9] || (rnd_e == 10'd0))
      result = {a_sign, 31'd0};
    else if (rnd_e >= 10'd255)
      result = a_sign ? NEG_INF : POS_INF;
    else
      result = {a_sign, rnd_e[7:0], rnd_m[24] ? rnd_m[23:1] : rnd_m[22:0]};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= POS_ZERO;
      op         <= POS_ZERO;
      last_q     <= 1'b0;
      count      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= POS_ZERO;
      out_count  <= '0;
      busy       <= 1'b0;
      a_sign     <= 1'b0;
      a_sub      <= 1'b0;
      a_both_neg <= 1'b0;
      a_spec     <= 1'b0;
      a_spec_val <= QNAN;
      a_exp      <= 8'd0;
      a_big      <= '0;
      a_small    <= '0;
      s_sum      <= '0;
      n_man      <= '0;
      n_exp      <= '0;
      n_zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid && in_ready) begin
          op       <= in_data;
          last_q   <= in_last;
          count    <= (&count) ? count : count + 1'b1;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= S_ALIGN;
        end
        S_ALIGN: begin
          a_sign     <= big_s;
          a_sub      <= acc.sign ^ op.sign;
          a_both_neg <= acc.sign & op.sign;
          a_spec     <= spec;
          a_spec_val <= spec_val;
          a_exp      <= big_e;
          a_big      <= {big_m, 3'b000};
          a_small    <= shifted;
          state      <= S_ADD;
        end
        S_ADD: begin
          s_sum <= a_sub ? ({1'b0, a_big} - {1'b0, a_small})
                         : ({1'b0, a_big} + {1'b0, a_small});
          state <= S_NORM;
        end
        S_NORM: begin
          n_man  <= norm_m;
          n_exp  <= norm_e;
          n_zero <= norm_z;
          state  <= S_ROUND;
        end
        S_ROUND: begin
          acc <= result;
          if (last_q) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_count <= count;
            state     <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_DONE: if (out_ready) begin
          acc       <= POS_ZERO;
          count     <= '0;
          out_valid <= 1'b0;
          out_data  <= POS_ZERO;
          out_count <= '0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_acc.sv
// Directed-vector bench for fp_acc: table of dot products plus handshake/reset sequences.
module tb_fp_acc;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int last_lat = 0;

  fp_acc #(.CNT_W(CNT_W), .FTZ(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    int              n;
    logic [2:0][31:0] d;
    logic [31:0]     exp_data;
    int              exp_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Returns just after the accepting clock edge.
  task automatic send(input logic [31:0] data, input logic last);
    int n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("send timeout in_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_last = 1'b0;
    end
  endtask

  task automatic collect(input string name, input logic [31:0] exp_data, input int exp_cnt);
    int n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    last_lat = n;
    check({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, " out_data"}, out_data, exp_data);
    check({name, " out_count"}, 32'(out_count), 32'(exp_cnt));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"sum123",     3, {32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 32'h40C0_0000, 3};
    vecs[1]  = '{"cancel",     2, {32'h0,         32'hBF80_0000, 32'h3F80_0000}, 32'h0000_0000, 2};
    vecs[2]  = '{"tie_even",   2, {32'h0,         32'h3380_0000, 32'h3F80_0001}, 32'h3F80_0002, 2};
    vecs[3]  = '{"inf_nan",    3, {32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000}, 32'h7FC0_0000, 3};
    vecs[4]  = '{"overflow",   2, {32'h0,         32'h7F7F_FFFF, 32'h7F7F_FFFF}, 32'h7F80_0000, 2};
    vecs[5]  = '{"sub_single", 1, {32'h0,         32'h0,         32'h0000_0001}, 32'h0000_0000, 1};
    vecs[6]  = '{"sub_add",    2, {32'h0,         32'h0040_0000, 32'h3F80_0000}, 32'h3F80_0000, 2};
    vecs[7]  = '{"neg_sub",    2, {32'h0,         32'h3E80_0000, 32'hBFC0_0000}, 32'hBFA0_0000, 2};
    vecs[8]  = '{"norm_left",  2, {32'h0,         32'hBFA0_0000, 32'h3FC0_0000}, 32'h3E80_0000, 2};
    vecs[9]  = '{"neg_zero",   1, {32'h0,         32'h0,         32'h8000_0000}, 32'h0000_0000, 1};
    vecs[10] = '{"inf_fin",    2, {32'h0,         32'hFF80_0000, 32'h3F80_0000}, 32'hFF80_0000, 2};
    vecs[11] = '{"nan_sticky", 3, {32'h4000_0000, 32'h3F80_0000, 32'h7F80_0001}, 32'h7FC0_0000, 3};

    repeat (3) @(negedge clk);
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_data",  out_data,           32'd0);
    check("reset out_count", 32'(out_count),     32'd0);
    check("reset busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency is counted in cycles from the last accept: ALIGN is cycle 1, DONE is cycle 5.
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < vecs[i].n; j++) send(vecs[i].d[j], j == vecs[i].n - 1);
      collect(vecs[i].name, vecs[i].exp_data, vecs[i].exp_cnt);
      check({vecs[i].name, " latency"}, 32'(last_lat), 32'd5);
    end

    // Back-pressure: hold the result for 10 cycles while offering a new product.
    send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b1);
    repeat (6) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h4100_0000;
    in_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold out_valid", {31'd0, out_valid}, 32'd1);
      check("hold out_data",  out_data,           32'h40A0_0000);
      check("hold in_ready",  {31'd0, in_ready},  32'd0);
    end
    check("hold out_count", 32'(out_count), 32'd2);
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("after release in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h3F80_0000, 1'b1);
    collect("fresh_sum", 32'h3F80_0000, 1);

    // Reset while the second element is in ADD.
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst out_data",  out_data,           32'd0);
    check("midrst out_count", 32'(out_count),     32'd0);
    check("midrst busy",      {31'd0, busy},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h4000_0000, 1'b1);
    collect("post_reset", 32'h4000_0000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_acc.md
Name: fp_acc

Overview:
- Sequential IEEE-754 single-precision accumulator placed directly downstream of the fp32 multiplier in the TPU MAC column.
- Consumes a stream of products over a valid/ready handshake and adds each one into a running fp32 sum.
- Uses a fixed 4-stage iterative adder: align, add, normalise, round.
- On the element flagged last, presents the final sum and element count, then clears for the next dot product.

Parameters:
- CNT_W, 16, width of the element counter.
- FTZ, 1, when 1, subnormal inputs and results flush to signed zero; 0 is not supported, and elaboration must error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  product available.
- in_ready  output  1  block can accept a product.
- in_data  input  32  fp32 product.
- in_last  input  1  final element of the current dot product.
- out_valid  output  1  sum available.
- out_ready  input  1  consumer takes the sum.
- out_data  output  32  fp32 accumulated sum.
- out_count  output  CNT_W  number of elements accepted for this sum.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state=IDLE, acc=+0 (0x00000000), count=0.
  - in_ready=1, out_valid=0, out_data=0, out_count=0, busy=0.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&in_ready: latch in_data and in_last, count+=1 (saturating at all-ones), go to ALIGN.
- ALIGN (1 cycle):
  - Unpack acc and operand with the hidden bit. Flush subnormal operands to zero.
  - Swap so the larger magnitude is first. Right-shift the smaller mantissa by the exponent difference, extended with 3 bits (guard, round, sticky).
  - Shifts of 26 or more give mantissa 0 with sticky=OR of all bits.
- ADD (1 cycle): add or subtract 27-bit magnitudes by effective sign; result sign = sign of the larger operand.
- NORM (1 cycle):
  - Carry out: shift right 1 (sticky preserved), exponent+1.
  - Otherwise: leading-zero count, left shift, exponent minus LZC.
  - Zero magnitude: result +0, except -0 + -0 gives -0.
- ROUND (1 cycle):
  - Round to nearest, ties to even.
  - A mantissa carry renormalises with exponent+1.
  - Exponent ≥255 gives signed infinity. Exponent ≤0 gives signed zero (FTZ).
  - Write acc. Go to DONE if the latched last is set, else IDLE.
- Throughput and latency:
  - One element per 5 cycles.
  - Sum visible on out_data 5 cycles after the accept edge of the last element.
- Special values, with NaN dominating all:
  - Any NaN operand, or inf + (-inf), sets acc = canonical NaN 0x7FC00000.
  - NaN is sticky until the sum is delivered.
  - inf + finite = that inf.
- DONE:
  - out_valid=1, out_data=acc, out_count=count, in_ready=0.
  - Outputs are held stable until out_ready.
  - On out_valid&out_ready: acc=+0, count=0, go to IDLE. in_ready=1 on the next cycle.
- in_ready=0 in every state except IDLE. in_valid while busy is ignored (no accept).
- An in_last element that is the first element gives out_data = that element. Subnormals flush, so -0 input gives +0 because acc starts at +0.
- Reset mid-operation discards the partial sum and any pending output immediately.

Decomposition:
- Shared package fp_pkg holds:
  - constants EXP_BIAS=127, EXP_MAX=8'hFF, QNAN=32'h7FC00000, POS_ZERO, POS_INF, NEG_INF;
  - a packed struct fp32_t {sign, exp[7:0], man[22:0]};
  - function is_nan/is_inf/is_zero.
- The multiplier shares the same package.
- One sub-module: fp_lzc27, a combinational 27-bit leading-zero counter (5-bit output) used in NORM.

Test Plan:
- Accumulate 0x3F800000, 0x40000000, 0x40400000 (last) -> out_data=0x40C00000 (6.0), out_count=3, out_valid 5 cycles after the last accept.
- Accumulate 0x3F800000, 0xBF800000 (last) -> out_data=0x00000000; then 0x3F800001, 0x33800000 (last, tie) -> 0x3F800002 (round to even).
- Accumulate 0x7F800000, 0xFF800000, 0x3F800000 (last) -> 0x7FC00000. Accumulate 0x7F7FFFFF, 0x7F7FFFFF (last) -> 0x7F800000.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, new in_valid not accepted. Then out_ready=1 -> next sum starts from +0.
- Single subnormal 0x00000001 (last) -> 0x00000000. Accumulate 0x3F800000, 0x00400000 (last) -> 0x3F800000.
- Assert rst_n=0 during ADD of the 2nd element -> all outputs reset immediately. Then 0x40000000 (last) -> 0x40000000, out_count=1.
